// File: rtl/lfsr_pkg.sv
// Shared types and helpers for the Berlekamp-Massey LFSR synthesizer.
package lfsr_pkg;

  typedef enum logic [1:0] {IDLE, ACCEPT, UPDATE, DONE} state_e;

  // Widest tap vector the discrepancy helper accepts; callers zero-extend.
  localparam int MAX_WIDTH = 64;

  function automatic int min_seq_len(input int data_width);
    return 2 * data_width;
  endfunction

  // d = s_n XOR (parity of history bits masked by the current taps).
  function automatic logic discrepancy(input logic s_n, input logic [MAX_WIDTH-1:0] taps);
    return s_n ^ (^taps);
  endfunction

endpackage

// File: rtl/lfsr_synthesizer_if.sv
// Stream-in / result-out bundle of the LFSR synthesizer.
interface lfsr_synthesizer_if
  import lfsr_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int SEQ_LEN    = min_seq_len(DATA_WIDTH),
  localparam int LW        = $clog2(SEQ_LEN + 1)
);

  logic                  start;
  logic                  bit_valid;
  logic                  bit_in;
  logic                  bit_ready;
  logic                  busy;
  logic                  done;
  logic                  overflow;
  logic [LW-1:0]         lin_complexity;
  logic [DATA_WIDTH:0]   feedback_coeff;

  modport master (
    output start, bit_valid, bit_in,
    input  bit_ready, busy, done, overflow, lin_complexity, feedback_coeff
  );

  modport slave (
    input  start, bit_valid, bit_in,
    output bit_ready, busy, done, overflow, lin_complexity, feedback_coeff
  );

endinterface

// File: rtl/lfsr_bm_step.sv
// Combinational Berlekamp-Massey update: next (C, B, L, m, n) from the current
// values and the discrepancy bit.
module lfsr_bm_step
  import lfsr_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int SEQ_LEN    = min_seq_len(DATA_WIDTH),
  localparam int CW        = DATA_WIDTH + 1,
  localparam int LW        = $clog2(SEQ_LEN + 1)
) (
  input  logic [CW-1:0] i_c,
  input  logic [CW-1:0] i_b,
  input  logic [LW-1:0] i_l,
  input  logic [LW-1:0] i_m,
  input  logic [LW-1:0] i_n,
  input  logic          i_d,
  output logic [CW-1:0] o_c,
  output logic [CW-1:0] o_b,
  output logic [LW-1:0] o_l,
  output logic [LW-1:0] o_m,
  output logic [LW-1:0] o_n
);

  logic [CW-1:0] w_b_shift;
  logic [LW:0]   w_two_l;
  logic [LW-1:0] w_m_inc;

  // NOTE: B<<m is deliberately truncated to the polynomial width; for m beyond
  // the degree bound the correction term simply vanishes.
  assign w_b_shift = i_b << i_m;
  assign w_two_l   = {i_l, 1'b0};
  assign w_m_inc   = (i_m == LW'(SEQ_LEN)) ? i_m : i_m + LW'(1);

  // NOTE: every output gets a default first so no path leaves it unassigned.
  always_comb begin
    o_c = i_c;
    o_b = i_b;
    o_l = i_l;
    o_m = w_m_inc;
    o_n = i_n + LW'(1);
    if (i_d) begin
      o_c = i_c ^ w_b_shift;
      if (w_two_l <= {1'b0, i_n}) begin
        o_l = i_n + LW'(1) - i_l;
        o_b = i_c;
        o_m = LW'(1);
      end
    end
  end

endmodule

// File: rtl/lfsr_synthesizer.sv
// Serial Berlekamp-Massey synthesizer: recovers linear complexity and the
// connection polynomial of a GF(2) stream, one bit every two cycles.
module lfsr_synthesizer
  import lfsr_pkg::*;
#(
  parameter int DATA_WIDTH = 6,
  parameter int SEQ_LEN    = min_seq_len(DATA_WIDTH),
  localparam int CW        = DATA_WIDTH + 1,
  localparam int LW        = $clog2(SEQ_LEN + 1)
) (
  input  logic               clk,
  input  logic               rst,
  lfsr_synthesizer_if.slave  bus
);

  state_e                r_state;
  logic [CW-1:0]         r_c;
  logic [CW-1:0]         r_b;
  logic [LW-1:0]         r_l;
  logic [LW-1:0]         r_m;
  logic [LW-1:0]         r_n;
  logic [DATA_WIDTH-1:0] r_hist;
  logic                  r_bit;
  logic                  r_bit_ready;
  logic                  r_busy;
  logic                  r_done;
  logic                  r_overflow;

  logic [DATA_WIDTH-1:0] w_taps;
  logic                  w_d;
  logic [CW-1:0]         w_c_nxt;
  logic [CW-1:0]         w_b_nxt;
  logic [LW-1:0]         w_l_nxt;
  logic [LW-1:0]         w_m_nxt;
  logic [LW-1:0]         w_n_nxt;

  // r_hist[j] = s_{n-1-j} lines up with tap c_{j+1}.
  assign w_taps = r_hist & r_c[CW-1:1];
  assign w_d    = discrepancy(r_bit, MAX_WIDTH'(w_taps));

  lfsr_bm_step #(
    .DATA_WIDTH (DATA_WIDTH),
    .SEQ_LEN    (SEQ_LEN)
  ) u_step (
    .i_c (r_c),
    .i_b (r_b),
    .i_l (r_l),
    .i_m (r_m),
    .i_n (r_n),
    .i_d (w_d),
    .o_c (w_c_nxt),
    .o_b (w_b_nxt),
    .o_l (w_l_nxt),
    .o_m (w_m_nxt),
    .o_n (w_n_nxt)
  );

  // NOTE: state uses non-blocking assignments so every register samples the
  // pre-edge values, exactly as the BM step expects.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_c         <= CW'(1);
      r_b         <= CW'(1);
      r_l         <= '0;
      r_m         <= LW'(1);
      r_n         <= '0;
      r_hist      <= '0;
      r_bit       <= 1'b0;
      r_bit_ready <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else if (bus.start) begin
      // NOTE: start outranks everything, including a bit offered in the same cycle.
      r_state     <= ACCEPT;
      r_c         <= CW'(1);
      r_b         <= CW'(1);
      r_l         <= '0;
      r_m         <= LW'(1);
      r_n         <= '0;
      r_hist      <= '0;
      r_bit_ready <= 1'b1;
      r_busy      <= 1'b1;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      case (r_state)
        ACCEPT: begin
          if (bus.bit_valid) begin
            r_bit       <= bus.bit_in;
            r_bit_ready <= 1'b0;
            r_state     <= UPDATE;
          end
        end
        UPDATE: begin
          r_c    <= w_c_nxt;
          r_b    <= w_b_nxt;
          r_l    <= w_l_nxt;
          r_m    <= w_m_nxt;
          r_n    <= w_n_nxt;
          r_hist <= {r_hist[DATA_WIDTH-2:0], r_bit};
          if (w_l_nxt > LW'(DATA_WIDTH)) r_overflow <= 1'b1;
          if (w_n_nxt == LW'(SEQ_LEN)) begin
            r_state <= DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else begin
            r_state     <= ACCEPT;
            r_bit_ready <= 1'b1;
          end
        end
        IDLE, DONE: ;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign bus.bit_ready      = r_bit_ready;
  assign bus.busy           = r_busy;
  assign bus.done           = r_done;
  assign bus.overflow       = r_overflow;
  assign bus.lin_complexity = r_l;
  assign bus.feedback_coeff = r_c;

endmodule
